parking_capacity_ctrl: RTL and testbench
========================================

Name: parking_capacity_ctrl

Overview:
Synchronous, parametrised successor of the university parking controller. It counts university and visitor cars from edge-detected gate requests and grants or denies each entry with a one-cycle pulse. It derives both zone capacities from a configurable hour-based shift schedule and reports free space, over-capacity conditions, sticky errors and a rejected-entry count. It takes hour from the existing clock_counter and drives the gate and display logic.

Parameters:
MAX_UNI_CAPACITY, 500, university spaces during the day period
MAX_OTHER_CAPACITY, 200, visitor spaces during the day period
NIGHT_UNI_CAPACITY, 200, university spaces from SHIFT_END_HOUR onward
RATE, 50, university spaces handed to visitors per shift hour
SHIFT_START_HOUR, 13, first hour of the linear shift
SHIFT_END_HOUR, 16, first hour of the night allocation
CNT_W, 10, width of counts, capacities and free-space outputs
REJ_W, 16, width of the rejected-entry counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  0 = parking closed: synchronously clears counts and errors
hour  in  5  current hour, 0..23, from clock_counter
entry_req  in  1  entry gate request, level; a rising edge is one event
entry_is_uni  in  1  class of the entry event, sampled on the same cycle as the edge
exit_req  in  1  exit gate request, level; a rising edge is one event
exit_is_uni  in  1  class of the exit event
err_clr  in  1  one-cycle pulse that clears the sticky errors and reject_count
uni_parked  out  CNT_W  university cars parked
parked_cars  out  CNT_W  visitor cars parked
uni_cap, other_cap  out  CNT_W  current capacities
uni_vacated_space, vacated_space  out  CNT_W  saturating free space
uni_is_vacated_space, is_vacated_space  out  1  free space > 0
entry_grant, entry_deny  out  1  one-cycle result pulses
exit_ack  out  1  one-cycle pulse for an accepted exit
uni_over, other_over  out  1  level: parked > cap
no_car_error, uni_capacity_error, capacity_error  out  1  sticky errors
reject_count  out  REJ_W  count of denied entries, saturating at all-ones

Behaviour:
- Reset (async, active-high):
  - All counts, pulses, errors and reject_count = 0.
  - Request edge-detect registers = 0.
  - uni_cap = MAX_UNI_CAPACITY; other_cap = MAX_OTHER_CAPACITY.
- Total capacity T = MAX_UNI_CAPACITY + MAX_OTHER_CAPACITY is constant; other_cap = T - uni_cap.
- University capacity, registered (1-cycle latency from hour):
  - hour < SHIFT_START_HOUR: MAX_UNI_CAPACITY.
  - SHIFT_START_HOUR <= hour < SHIFT_END_HOUR: MAX_UNI_CAPACITY - (hour - SHIFT_START_HOUR + 1) * RATE, floored at NIGHT_UNI_CAPACITY.
  - hour >= SHIFT_END_HOUR, including out-of-range values 24..31: NIGHT_UNI_CAPACITY.
  - Compute in a CNT_W+8 bit intermediate; no wrap is permitted.
- Free space = cap > parked ? cap - parked : 0, computed from the registered values.
- Event detection: an event is req & ~req_q, with req_q registered each cycle. Class is sampled on the edge cycle. Results appear one cycle after the edge.
- Entry of class C:
  - Granted if free_C > 0, or if a same-class exit is accepted in the same cycle.
  - Grant: count_C increments and entry_grant pulses.
  - Deny: entry_deny pulses, reject_count increments, and the class capacity error is set (uni_capacity_error for uni, capacity_error for visitor).
- Exit of class C:
  - count_C > 0: decrement and pulse exit_ack.
  - count_C = 0: set no_car_error; the count is unchanged.
- Simultaneous entry and exit:
  - Both are resolved in the same cycle.
  - Same class, both accepted: count unchanged.
  - Different classes: each is handled independently.
- Capacity shrink below the current count:
  - Sets uni_over / other_over (level) and the matching sticky capacity error.
  - Cars are never evicted; free space reads 0 until the count drops.
- Sticky errors: cleared by err_clr, unless a new error fires in the same cycle, in which case set wins.
- enable = 0:
  - Next edge clears counts, errors, pulses and reject_count. Capacity tracking continues.
  - Request edges are ignored, and req_q still tracks so no stale event fires when enable returns.
- Reset asserted mid-event: the event is dropped and no pulse is produced.

Test Plan:
- Reset, then enable=1, hour=9 -> uni_cap=500, other_cap=200, uni_vacated_space=500, all outputs otherwise 0.
- Override MAX_UNI_CAPACITY=4, send 5 uni entry edges at hour=9 -> four entry_grant pulses, uni_parked=4, fifth gives entry_deny, reject_count=1, uni_capacity_error=1.
- With uni_parked=4 (cap 4), entry and exit uni edges in the same cycle -> entry_grant and exit_ack both pulse, uni_parked stays 4, no error.
- Exit visitor edge with parked_cars=0 -> no_car_error=1, no exit_ack; err_clr pulse -> no_car_error=0.
- Defaults with 460 uni cars, step hour 12->13->14->16 -> uni_cap 500/450/400/200, other_cap 200/250/300/500. uni_over=1 from hour 13 onward, uni_vacated_space=0.
- Hold entry_req high for 10 cycles -> exactly one event. Drop enable for 1 cycle -> all counts and errors 0, caps unchanged.

Source files
------------

// File: rtl/parking_capacity_ctrl.sv
// Parking capacity controller: counts university and visitor cars and grants or denies gate entries.
// Latency: the entry/exit result pulses and counts appear one cycle after the request edge; capacity follows hour one cycle later.
// No backpressure: each request edge is resolved in the cycle after it, and a held request level produces only one event.
module parking_capacity_ctrl #(
  parameter int MAX_UNI_CAPACITY   = 500,
  parameter int MAX_OTHER_CAPACITY = 200,
  parameter int NIGHT_UNI_CAPACITY = 200,
  parameter int RATE               = 50,
  parameter int SHIFT_START_HOUR   = 13,
  parameter int SHIFT_END_HOUR     = 16,
  parameter int CNT_W              = 10,
  parameter int REJ_W              = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [4:0]       hour,
  input  logic             entry_req,
  input  logic             entry_is_uni,
  input  logic             exit_req,
  input  logic             exit_is_uni,
  input  logic             err_clr,
  output logic [CNT_W-1:0] uni_parked,
  output logic [CNT_W-1:0] parked_cars,
  output logic [CNT_W-1:0] uni_cap,
  output logic [CNT_W-1:0] other_cap,
  output logic [CNT_W-1:0] uni_vacated_space,
  output logic [CNT_W-1:0] vacated_space,
  output logic             uni_is_vacated_space,
  output logic             is_vacated_space,
  output logic             entry_grant,
  output logic             entry_deny,
  output logic             exit_ack,
  output logic             uni_over,
  output logic             other_over,
  output logic             no_car_error,
  output logic             uni_capacity_error,
  output logic             capacity_error,
  output logic [REJ_W-1:0] reject_count
);

  localparam int IW = CNT_W + 8;
  localparam logic [CNT_W-1:0] TOTAL_CAP = CNT_W'(MAX_UNI_CAPACITY + MAX_OTHER_CAPACITY);
  localparam logic [CNT_W-1:0] DAY_CAP   = CNT_W'(MAX_UNI_CAPACITY);

  logic             entry_q, exit_q;
  logic [IW-1:0]    hour_w, shift_amt, cap_calc;
  logic [CNT_W-1:0] uni_cap_next;
  logic             entry_ev, exit_ev;
  logic             exit_uni_ok, exit_oth_ok, exit_fail;
  logic             entry_uni_ok, entry_oth_ok, entry_ok, entry_bad;
  logic             set_uni_err, set_oth_err, set_nce;
  logic [CNT_W-1:0] uni_next, oth_next;

  // Visitor capacity is whatever the university share leaves of the fixed total.
  assign other_cap = TOTAL_CAP - uni_cap;

  // Free space never wraps: a shrunken capacity simply reads as zero free space.
  assign uni_vacated_space    = (uni_cap > uni_parked) ? uni_cap - uni_parked : '0;
  assign vacated_space        = (other_cap > parked_cars) ? other_cap - parked_cars : '0;
  assign uni_is_vacated_space = (uni_vacated_space != '0);
  assign is_vacated_space     = (vacated_space != '0);
  assign uni_over             = (uni_parked > uni_cap);
  assign other_over           = (parked_cars > other_cap);

  // Hour schedule: day allocation, then a linear hand-over to visitors, then the night allocation.
  always_comb begin
    hour_w    = IW'(hour);
    shift_amt = (hour_w - IW'(SHIFT_START_HOUR) + IW'(1)) * IW'(RATE);
    cap_calc  = IW'(NIGHT_UNI_CAPACITY);
    if (hour_w < IW'(SHIFT_START_HOUR)) begin
      cap_calc = IW'(MAX_UNI_CAPACITY);
    end else if (hour_w < IW'(SHIFT_END_HOUR)) begin
      // Compare before subtracting so the reduction can never wrap below the night floor.
      if (shift_amt + IW'(NIGHT_UNI_CAPACITY) < IW'(MAX_UNI_CAPACITY)) begin
        cap_calc = IW'(MAX_UNI_CAPACITY) - shift_amt;
      end
    end
    uni_cap_next = cap_calc[CNT_W-1:0];
  end

  // Event resolution: exits are judged first so a same-class exit can make room for an entry.
  always_comb begin
    entry_ev     = enable & entry_req & ~entry_q;
    exit_ev      = enable & exit_req & ~exit_q;
    exit_uni_ok  = exit_ev & exit_is_uni & (uni_parked != '0);
    exit_oth_ok  = exit_ev & ~exit_is_uni & (parked_cars != '0);
    exit_fail    = exit_ev & ~(exit_uni_ok | exit_oth_ok);
    entry_uni_ok = entry_ev & entry_is_uni & (uni_is_vacated_space | exit_uni_ok);
    entry_oth_ok = entry_ev & ~entry_is_uni & (is_vacated_space | exit_oth_ok);
    entry_ok     = entry_uni_ok | entry_oth_ok;
    entry_bad    = entry_ev & ~entry_ok;
    set_uni_err  = (entry_bad & entry_is_uni) | uni_over;
    set_oth_err  = (entry_bad & ~entry_is_uni) | other_over;
    set_nce      = exit_fail;
    uni_next     = uni_parked;
    oth_next     = parked_cars;
    if (entry_uni_ok && !exit_uni_ok) uni_next = uni_parked + CNT_W'(1);
    else if (exit_uni_ok && !entry_uni_ok) uni_next = uni_parked - CNT_W'(1);
    if (entry_oth_ok && !exit_oth_ok) oth_next = parked_cars + CNT_W'(1);
    else if (exit_oth_ok && !entry_oth_ok) oth_next = parked_cars - CNT_W'(1);
  end

  // Request history tracks the raw levels even while closed, so reopening never fires a stale event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      entry_q <= entry_req;
      exit_q  <= exit_req;
    end
  end

  // Capacity keeps following the schedule regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) uni_cap <= DAY_CAP;
    else       uni_cap <= uni_cap_next;
  end

  // Counts and result pulses; closing the car park empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      uni_parked  <= '0;
      parked_cars <= '0;
      entry_grant <= 1'b0;
      entry_deny  <= 1'b0;
      exit_ack    <= 1'b0;
    end else begin
      uni_parked  <= uni_next;
      parked_cars <= oth_next;
      entry_grant <= entry_ok;
      entry_deny  <= entry_bad;
      exit_ack    <= exit_uni_ok | exit_oth_ok;
    end
  end

  // Sticky errors and the reject counter; a fresh error beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      no_car_error       <= 1'b0;
      uni_capacity_error <= 1'b0;
      capacity_error     <= 1'b0;
      reject_count       <= '0;
    end else begin
      no_car_error       <= (no_car_error & ~err_clr) | set_nce;
      uni_capacity_error <= (uni_capacity_error & ~err_clr) | set_uni_err;
      capacity_error     <= (capacity_error & ~err_clr) | set_oth_err;
      if (err_clr) reject_count <= entry_bad ? REJ_W'(1) : '0;
      else if (entry_bad && reject_count != {REJ_W{1'b1}}) reject_count <= reject_count + REJ_W'(1);
    end
  end

endmodule

// File: tb/tb_parking_capacity_ctrl.sv
// Bench for parking_capacity_ctrl: a default instance and a small-capacity instance share one stimulus stream.
// A spec-level model is compared against both every cycle; literal checks pin key points of the scenario.
module tb_parking_capacity_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [4:0] hour;
  logic       entry_req, entry_is_uni, exit_req, exit_is_uni, err_clr;

  logic [9:0]  up_o [2];
  logic [9:0]  pc_o [2];
  logic [9:0]  ucap_o [2];
  logic [9:0]  ocap_o [2];
  logic [9:0]  uvac_o [2];
  logic [9:0]  vac_o [2];
  logic        uis_o [2];
  logic        is_o [2];
  logic        g_o [2];
  logic        d_o [2];
  logic        a_o [2];
  logic        uov_o [2];
  logic        oov_o [2];
  logic        nce_o [2];
  logic        ue_o [2];
  logic        ce_o [2];
  logic [15:0] rej_o [2];

  int total = 0;
  int bad   = 0;

  parking_capacity_ctrl dut0 (
    .clk(clk), .reset(reset), .enable(enable), .hour(hour),
    .entry_req(entry_req), .entry_is_uni(entry_is_uni),
    .exit_req(exit_req), .exit_is_uni(exit_is_uni), .err_clr(err_clr),
    .uni_parked(up_o[0]), .parked_cars(pc_o[0]), .uni_cap(ucap_o[0]), .other_cap(ocap_o[0]),
    .uni_vacated_space(uvac_o[0]), .vacated_space(vac_o[0]),
    .uni_is_vacated_space(uis_o[0]), .is_vacated_space(is_o[0]),
    .entry_grant(g_o[0]), .entry_deny(d_o[0]), .exit_ack(a_o[0]),
    .uni_over(uov_o[0]), .other_over(oov_o[0]),
    .no_car_error(nce_o[0]), .uni_capacity_error(ue_o[0]), .capacity_error(ce_o[0]),
    .reject_count(rej_o[0])
  );

  parking_capacity_ctrl #(
    .MAX_UNI_CAPACITY(4), .MAX_OTHER_CAPACITY(3), .NIGHT_UNI_CAPACITY(2), .RATE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .hour(hour),
    .entry_req(entry_req), .entry_is_uni(entry_is_uni),
    .exit_req(exit_req), .exit_is_uni(exit_is_uni), .err_clr(err_clr),
    .uni_parked(up_o[1]), .parked_cars(pc_o[1]), .uni_cap(ucap_o[1]), .other_cap(ocap_o[1]),
    .uni_vacated_space(uvac_o[1]), .vacated_space(vac_o[1]),
    .uni_is_vacated_space(uis_o[1]), .is_vacated_space(is_o[1]),
    .entry_grant(g_o[1]), .entry_deny(d_o[1]), .exit_ack(a_o[1]),
    .uni_over(uov_o[1]), .other_over(oov_o[1]),
    .no_car_error(nce_o[1]), .uni_capacity_error(ue_o[1]), .capacity_error(ce_o[1]),
    .reject_count(rej_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int cap_of(int i, int h);
    int mu, nu, r, s, e, v;
    if (i == 0) begin mu = 500; nu = 200; r = 50; s = 13; e = 16; end
    else        begin mu = 4;   nu = 2;   r = 1;  s = 13; e = 16; end
    if (h < s)  return mu;
    if (h >= e) return nu;
    v = mu - (h - s + 1) * r;
    return (v > nu) ? v : nu;
  endfunction

  function automatic int tot(int i);
    return (i == 0) ? 700 : 7;
  endfunction

  function automatic int sat_sub(int a, int b);
    return (a > b) ? a - b : 0;
  endfunction

  int m_up [2];
  int m_pc [2];
  int m_ucap [2];
  int m_rej [2];
  bit m_g [2];
  bit m_d [2];
  bit m_a [2];
  bit m_nce [2];
  bit m_ue [2];
  bit m_ce [2];
  bit m_eq, m_xq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_up[i] = 0; m_pc[i] = 0; m_ucap[i] = cap_of(i, 0); m_rej[i] = 0;
        m_g[i] = 0; m_d[i] = 0; m_a[i] = 0; m_nce[i] = 0; m_ue[i] = 0; m_ce[i] = 0;
      end
      m_eq = 0; m_xq = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        int ocap;
        bit ev_en, ev_ex, xok, gok, deny, new_u, new_o, new_n;
        ocap  = tot(i) - m_ucap[i];
        ev_en = enable && entry_req && !m_eq;
        ev_ex = enable && exit_req && !m_xq;
        if (!enable) begin
          m_up[i] = 0; m_pc[i] = 0; m_rej[i] = 0;
          m_g[i] = 0; m_d[i] = 0; m_a[i] = 0; m_nce[i] = 0; m_ue[i] = 0; m_ce[i] = 0;
        end else begin
          xok = ev_ex && (exit_is_uni ? (m_up[i] > 0) : (m_pc[i] > 0));
          if (entry_is_uni) gok = ev_en && (m_up[i] < m_ucap[i] || (xok && exit_is_uni));
          else              gok = ev_en && (m_pc[i] < ocap || (xok && !exit_is_uni));
          deny  = ev_en && !gok;
          new_u = (deny && entry_is_uni) || (m_up[i] > m_ucap[i]);
          new_o = (deny && !entry_is_uni) || (m_pc[i] > ocap);
          new_n = ev_ex && !xok;
          if (gok) begin if (entry_is_uni) m_up[i]++; else m_pc[i]++; end
          if (xok) begin if (exit_is_uni) m_up[i]--; else m_pc[i]--; end
          if (err_clr) m_rej[i] = deny ? 1 : 0;
          else if (deny && m_rej[i] < 65535) m_rej[i]++;
          m_nce[i] = (m_nce[i] && !err_clr) || new_n;
          m_ue[i]  = (m_ue[i] && !err_clr) || new_u;
          m_ce[i]  = (m_ce[i] && !err_clr) || new_o;
          m_g[i] = gok; m_d[i] = deny; m_a[i] = xok;
        end
        m_ucap[i] = cap_of(i, int'(hour));
      end
      m_eq = entry_req;
      m_xq = exit_req;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, int inst, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, inst, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < 2; i++) begin
        int ocap;
        ocap = tot(i) - m_ucap[i];
        chk("uni_parked", i, int'(up_o[i]), m_up[i]);
        chk("parked_cars", i, int'(pc_o[i]), m_pc[i]);
        chk("uni_cap", i, int'(ucap_o[i]), m_ucap[i]);
        chk("other_cap", i, int'(ocap_o[i]), ocap);
        chk("uni_vacated_space", i, int'(uvac_o[i]), sat_sub(m_ucap[i], m_up[i]));
        chk("vacated_space", i, int'(vac_o[i]), sat_sub(ocap, m_pc[i]));
        chk("uni_is_vacated_space", i, int'(uis_o[i]), int'(m_ucap[i] > m_up[i]));
        chk("is_vacated_space", i, int'(is_o[i]), int'(ocap > m_pc[i]));
        chk("entry_grant", i, int'(g_o[i]), int'(m_g[i]));
        chk("entry_deny", i, int'(d_o[i]), int'(m_d[i]));
        chk("exit_ack", i, int'(a_o[i]), int'(m_a[i]));
        chk("uni_over", i, int'(uov_o[i]), int'(m_up[i] > m_ucap[i]));
        chk("other_over", i, int'(oov_o[i]), int'(m_pc[i] > ocap));
        chk("no_car_error", i, int'(nce_o[i]), int'(m_nce[i]));
        chk("uni_capacity_error", i, int'(ue_o[i]), int'(m_ue[i]));
        chk("capacity_error", i, int'(ce_o[i]), int'(m_ce[i]));
        chk("reject_count", i, int'(rej_o[i]), m_rej[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ent(bit uni);
    entry_req = 1'b1; entry_is_uni = uni;
    cyc(1);
    entry_req = 1'b0;
    cyc(1);
  endtask

  task automatic clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  task automatic set_hour(int h);
    hour = 5'(h);
    cyc(2);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; hour = 5'd9;
    entry_req = 0; entry_is_uni = 0; exit_req = 0; exit_is_uni = 0; err_clr = 0;
    cyc(3);
    reset = 1'b0; enable = 1'b1;
    cyc(2);
    chk("lit_reset_uni_cap", 0, int'(ucap_o[0]), 500);
    chk("lit_reset_other_cap", 0, int'(ocap_o[0]), 200);
    chk("lit_reset_uni_vac", 0, int'(uvac_o[0]), 500);
    chk("lit_reset_uni_parked", 0, int'(up_o[0]), 0);
    chk("lit_small_uni_cap", 1, int'(ucap_o[1]), 4);

    // Fill the small instance: four grants then a deny.
    for (int k = 0; k < 5; k++) ent(1'b1);
    chk("lit_fill_uni_parked", 1, int'(up_o[1]), 4);
    chk("lit_fill_reject", 1, int'(rej_o[1]), 1);
    chk("lit_fill_uerr", 1, int'(ue_o[1]), 1);
    chk("lit_fill_default_parked", 0, int'(up_o[0]), 5);
    clr();
    chk("lit_clr_uerr", 1, int'(ue_o[1]), 0);
    chk("lit_clr_reject", 1, int'(rej_o[1]), 0);

    // Simultaneous same-class entry and exit at full capacity.
    entry_req = 1'b1; entry_is_uni = 1'b1; exit_req = 1'b1; exit_is_uni = 1'b1;
    cyc(1);
    chk("lit_swap_grant", 1, int'(g_o[1]), 1);
    chk("lit_swap_ack", 1, int'(a_o[1]), 1);
    entry_req = 1'b0; exit_req = 1'b0;
    cyc(1);
    chk("lit_swap_parked", 1, int'(up_o[1]), 4);
    chk("lit_swap_uerr", 1, int'(ue_o[1]), 0);

    // Visitor exit from an empty visitor zone.
    exit_req = 1'b1; exit_is_uni = 1'b0;
    cyc(1);
    chk("lit_empty_exit_ack", 0, int'(a_o[0]), 0);
    exit_req = 1'b0;
    cyc(1);
    chk("lit_empty_exit_nce", 0, int'(nce_o[0]), 1);
    clr();
    chk("lit_empty_exit_nce_clr", 0, int'(nce_o[0]), 0);

    // Bring the default instance to 460 university cars, then walk the schedule.
    for (int k = 0; k < 455; k++) ent(1'b1);
    chk("lit_460_parked", 0, int'(up_o[0]), 460);
    set_hour(12);
    chk("lit_h12_uni_cap", 0, int'(ucap_o[0]), 500);
    chk("lit_h12_uni_vac", 0, int'(uvac_o[0]), 40);
    chk("lit_h12_over", 0, int'(uov_o[0]), 0);
    set_hour(13);
    chk("lit_h13_uni_cap", 0, int'(ucap_o[0]), 450);
    chk("lit_h13_other_cap", 0, int'(ocap_o[0]), 250);
    chk("lit_h13_over", 0, int'(uov_o[0]), 1);
    chk("lit_h13_uni_vac", 0, int'(uvac_o[0]), 0);
    chk("lit_h13_small_cap", 1, int'(ucap_o[1]), 3);
    set_hour(14);
    chk("lit_h14_uni_cap", 0, int'(ucap_o[0]), 400);
    chk("lit_h14_other_cap", 0, int'(ocap_o[0]), 300);
    chk("lit_h14_uerr", 0, int'(ue_o[0]), 1);
    set_hour(15);
    chk("lit_h15_uni_cap", 0, int'(ucap_o[0]), 350);
    set_hour(16);
    chk("lit_h16_uni_cap", 0, int'(ucap_o[0]), 200);
    chk("lit_h16_other_cap", 0, int'(ocap_o[0]), 500);
    chk("lit_h16_over", 0, int'(uov_o[0]), 1);
    set_hour(27);
    chk("lit_h27_uni_cap", 0, int'(ucap_o[0]), 200);
    set_hour(16);

    // A held request is a single event.
    entry_req = 1'b1; entry_is_uni = 1'b0;
    cyc(10);
    entry_req = 1'b0;
    cyc(1);
    chk("lit_hold_parked", 0, int'(pc_o[0]), 1);

    // Closing for one cycle empties everything but keeps the schedule.
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    cyc(1);
    chk("lit_close_uni_parked", 0, int'(up_o[0]), 0);
    chk("lit_close_parked", 0, int'(pc_o[0]), 0);
    chk("lit_close_uerr", 0, int'(ue_o[0]), 0);
    chk("lit_close_reject", 1, int'(rej_o[1]), 0);
    chk("lit_close_uni_cap", 0, int'(ucap_o[0]), 200);

    // Reset arriving on an event edge drops that event.
    entry_req = 1'b1; entry_is_uni = 1'b1;
    #2 reset = 1'b1;
    cyc(1);
    entry_req = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(2);
    chk("lit_rst_event_parked", 0, int'(up_o[0]), 0);
    chk("lit_rst_event_grant", 0, int'(g_o[0]), 0);
    ent(1'b1);
    chk("lit_after_rst_parked", 0, int'(up_o[0]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
